reg_arbiter: RTL
================

REG_ARBITER -- requirements
Module: reg_arbiter

Interface
REQ-001 The block SHALL provide parameter WIDTH, default 8, the data width of each register and of the bus.
REQ-002 The block SHALL provide parameter AW, default 2, the register address width; NREG = 2**AW registers.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Ports a_req / b_req  input  1  access request from requester A / B; held high until the matching ack.
REQ-006 Ports a_wr / b_wr  input  1  1 = load wdata into register, 0 = read register.
REQ-007 Ports a_addr / b_addr  input  AW  target register index.
REQ-008 Ports a_wdata / b_wdata  input  WIDTH  data to load.
REQ-009 Ports a_ack / b_ack  output  1  one-cycle completion pulse to A / B.
REQ-010 Port rdata  output  WIDTH  read result; valid in the ack cycle and held until the next read completes.
REQ-011 Port reg_d  output  WIDTH  shared d bus to all registers.
REQ-012 Port reg_re_n  output  NREG  per-register load strobe, active-low; the register captures d while low.
REQ-013 Port reg_we_n  output  NREG  per-register output enable, active-low; the register drives q while low.
REQ-014 Port reg_q  input  WIDTH  shared q bus from all registers.
REQ-015 Port busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, LOAD, DRV1, DRV2 and DONE.
REQ-017 In IDLE with any req high, the FSM SHALL pick a winner (REQ-024), latch its wr, addr and wdata, and go to LOAD if wr=1 or DRV1 if wr=0.
REQ-018 LOAD (1 cycle): reg_re_n[addr]=0 and reg_d=latched wdata; then go to DONE.
REQ-019 DRV1 and DRV2 (1 cycle each): reg_we_n[addr]=0; at the end of DRV2, rdata SHALL capture reg_q; then go to DONE.
REQ-020 DONE (1 cycle): the winner's ack SHALL be 1; then go to IDLE.
REQ-021 Latency from the first IDLE cycle with req high to the ack cycle: load = 2 cycles, read = 3 cycles.
REQ-022 At most one bit of reg_re_n and reg_we_n SHALL be low in any cycle; re_n and we_n SHALL never be low together.
REQ-023 Outside LOAD, reg_d SHALL hold its last value; it SHALL not toggle in DRV1, DRV2 or DONE.
REQ-024 Arbitration: if only one req is high, that requester wins; on simultaneous requests, the winner follows REQ-030/031.
REQ-025 A req that drops after grant SHALL not abort the operation; the ack is still issued.
REQ-026 A requester SHALL drop req in the cycle after its ack; the IDLE cycle after DONE SHALL re-arbitrate, so there is a minimum 1-cycle IDLE gap between operations.
REQ-027 Request inputs SHALL be ignored outside IDLE; the losing request stays pending.

Reset
REQ-028 With rst high at a clock edge, the FSM SHALL go to IDLE and SHALL set:
- reg_re_n and reg_we_n all 1
- reg_d = 0, rdata = 0
- a_ack, b_ack and busy = 0
- the round-robin pointer to favour A
REQ-029 Reset mid-operation SHALL abort it with no ack; strobes SHALL be deasserted in the cycle after the reset edge.

Configuration
REQ-030 With macro REG_ARBITER_RR_EN defined, simultaneous requests SHALL be resolved round-robin: the winner is the requester not granted last, and the pointer updates on each grant.
REQ-031 Without REG_ARBITER_RR_EN, A SHALL always win simultaneous requests (fixed priority) and no pointer register SHALL exist.

Verification
REQ-032 Reset mid-LOAD: assert rst during the LOAD of A load addr2 0x5A -> next cycle all strobes are 1, busy=0, no ack; register 2 is not guaranteed loaded.
REQ-033 A load then read: A loads addr1 0xA5, then reads addr1 ->
- reg_re_n=4'b1101 for exactly 1 cycle; a_ack 2 cycles after req
- reg_we_n=4'b1101 for 2 cycles; a_ack with rdata=0xA5, 3 cycles after req
REQ-034 Simultaneous loads: A and B request loads in the same cycle (A addr0 0x11, B addr3 0x33) -> A is served first, then B after the 1-cycle IDLE gap; registers read back 0x11 and 0x33.
REQ-035 Contention under REG_ARBITER_RR_EN: A and B request continuously for 4 operations ->
- with the macro: grants alternate A, B, A, B
- without the macro: A wins every contested cycle
REQ-036 Request dropped mid-read: B drops req during DRV1 -> the read completes, b_ack pulses once, rdata = register contents.

Source files
------------

// File: rtl/reg_arbiter.sv
// Two-requester arbiter for a bank of NREG external registers sharing one
// d bus (active-low load strobes) and one q bus (active-low output enables).
// Each operation is a load (LOAD, DONE) or a read (DRV1, DRV2, DONE).
// Optional feature: define REG_ARBITER_RR_EN to resolve simultaneous requests
// round-robin. Without it, requester A has fixed priority.
module reg_arbiter #(
   parameter int WIDTH = 8,
   parameter int AW    = 2,
   localparam int NREG = 2**AW
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             a_req,
   input  logic             a_wr,
   input  logic [AW-1:0]    a_addr,
   input  logic [WIDTH-1:0] a_wdata,
   input  logic             b_req,
   input  logic             b_wr,
   input  logic [AW-1:0]    b_addr,
   input  logic [WIDTH-1:0] b_wdata,
   output logic             a_ack,
   output logic             b_ack,
   output logic [WIDTH-1:0] rdata,
   output logic [WIDTH-1:0] reg_d,
   output logic [NREG-1:0]  reg_re_n,
   output logic [NREG-1:0]  reg_we_n,
   input  logic [WIDTH-1:0] reg_q,
   output logic             busy
);

   typedef enum logic [2:0] {IDLE, LOAD, DRV1, DRV2, DONE} state_t;

   state_t           state_reg;
   logic             win_b_reg;   // 1 when B owns the operation in flight
   logic             prefer_b;
   logic             grant_b;
   logic             sel_wr;
   logic [AW-1:0]    sel_addr;
   logic [WIDTH-1:0] sel_wdata;
   logic [NREG-1:0]  sel_strobe_n;

`ifdef REG_ARBITER_RR_EN
   logic             last_b_reg;  // 1 when B received the most recent grant

   assign prefer_b = ~last_b_reg;
`else
   assign prefer_b = 1'b0;
`endif

   // Pick the winner among the live requests and decode its strobe pattern.
   always_comb begin
      grant_b      = b_req & (~a_req | prefer_b);
      sel_wr       = grant_b ? b_wr    : a_wr;
      sel_addr     = grant_b ? b_addr  : a_addr;
      sel_wdata    = grant_b ? b_wdata : a_wdata;
      sel_strobe_n = ~(NREG'(1) << sel_addr);
   end

   // Operation sequencer; every bus-facing output is a register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         win_b_reg <= 1'b0;
         reg_re_n  <= {NREG{1'b1}};
         reg_we_n  <= {NREG{1'b1}};
         reg_d     <= '0;
         rdata     <= '0;
         a_ack     <= 1'b0;
         b_ack     <= 1'b0;
         busy      <= 1'b0;
`ifdef REG_ARBITER_RR_EN
         last_b_reg <= 1'b1;
`endif
      end else begin
         case (state_reg)
            IDLE: begin
               a_ack <= 1'b0;
               b_ack <= 1'b0;
               if (a_req || b_req) begin
                  win_b_reg <= grant_b;
                  busy      <= 1'b1;
`ifdef REG_ARBITER_RR_EN
                  last_b_reg <= grant_b;
`endif
                  if (sel_wr) begin
                     reg_re_n  <= sel_strobe_n;
                     reg_d     <= sel_wdata;
                     state_reg <= LOAD;
                  end else begin
                     reg_we_n  <= sel_strobe_n;
                     state_reg <= DRV1;
                  end
               end
            end
            LOAD: begin
               reg_re_n  <= {NREG{1'b1}};
               a_ack     <= ~win_b_reg;
               b_ack     <= win_b_reg;
               state_reg <= DONE;
            end
            DRV1: begin
               state_reg <= DRV2;
            end
            DRV2: begin
               rdata     <= reg_q;
               reg_we_n  <= {NREG{1'b1}};
               a_ack     <= ~win_b_reg;
               b_ack     <= win_b_reg;
               state_reg <= DONE;
            end
            DONE: begin
               a_ack     <= 1'b0;
               b_ack     <= 1'b0;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
            default: begin
               reg_re_n  <= {NREG{1'b1}};
               reg_we_n  <= {NREG{1'b1}};
               a_ack     <= 1'b0;
               b_ack     <= 1'b0;
               busy      <= 1'b0;
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule
